// File: rtl/dm_arbiter.sv
// Two-master data-memory port arbiter: CPU MEM stage vs DMA/debug, one
// outstanding access at a time with slave timeout and registered slave side.
module dm_arbiter #(
   parameter int unsigned MAX_CPU_RUN = 4,
   parameter int unsigned TIMEOUT     = 16
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic [3:0]  cpu_we,
   input  logic [31:0] cpu_wdata,
   input  logic [31:0] cpu_pc,
   output logic        cpu_stall,
   output logic [31:0] cpu_rdata,

   input  logic        dma_req,
   input  logic [31:0] dma_addr,
   input  logic [3:0]  dma_we,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic        dma_done,
   output logic [31:0] dma_rdata,

   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_pc,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,

   output logic        bus_err
);

   localparam int unsigned RUN_W  = 4;
   localparam int unsigned WAIT_W = 8;
   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_CPU_RUN);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [31:0] pc;
   } mem_cmd_t;

   state_e             state_q, state_d;
   logic               owner_q, owner_d;
   logic [RUN_W-1:0]   run_q, run_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   mem_cmd_t           cmd_q, cmd_d;
   logic               mem_req_q, mem_req_d;
   logic [31:0]        cpu_rdata_q, cpu_rdata_d;
   logic [31:0]        dma_rdata_q, dma_rdata_d;
   logic               dma_done_q, dma_done_d;
   logic               dma_gnt_q, dma_gnt_d;
   logic               bus_err_q, bus_err_d;
   logic               grant_cpu_c, grant_dma_c;
   logic [31:0]        done_data_c;

   // Word alignment drops the byte-offset bits on both masters.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[1:0], dma_addr[1:0]};

   // Next-state, arbitration and slave-side register updates.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      run_d       = run_q;
      wait_d      = wait_q;
      cmd_d       = cmd_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      dma_done_d  = 1'b0;
      bus_err_d   = 1'b0;
      grant_cpu_c = 1'b0;
      grant_dma_c = 1'b0;
      done_data_c = mem_ready ? mem_rdata : 32'h0;

      unique case (state_q)
         S_IDLE: begin
            wait_d = '0;
            if (dma_req && (!cpu_req || run_q == RUN_MAX)) begin
               grant_dma_c = 1'b1;
            end else if (cpu_req) begin
               grant_cpu_c = 1'b1;
            end
            if (grant_cpu_c) begin
               cmd_d.addr  = {cpu_addr[31:2], 2'b00};
               cmd_d.we    = cpu_we;
               cmd_d.wdata = cpu_wdata;
               cmd_d.pc    = cpu_pc;
               owner_d     = 1'b0;
               state_d     = S_BUSY;
            end else if (grant_dma_c) begin
               cmd_d.addr  = {dma_addr[31:2], 2'b00};
               cmd_d.we    = dma_we;
               cmd_d.wdata = dma_wdata;
               cmd_d.pc    = 32'h0;
               owner_d     = 1'b1;
               state_d     = S_BUSY;
            end
         end
         S_BUSY: begin
            wait_d = wait_q + WAIT_W'(1);
            // Ready wins over a timeout landing in the same cycle.
            if (mem_ready || wait_q == WAIT_LAST) begin
               state_d    = S_RESP;
               cmd_d      = '0;
               wait_d     = '0;
               dma_done_d = owner_q;
               bus_err_d  = !mem_ready;
               if (owner_q) dma_rdata_d = done_data_c;
               else         cpu_rdata_d = done_data_c;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // CPU fairness run length, only meaningful while DMA is waiting.
      if (!dma_req || grant_dma_c) begin
         run_d = '0;
      end else if (grant_cpu_c && run_q != RUN_MAX) begin
         run_d = run_q + RUN_W'(1);
      end

      mem_req_d = (state_d == S_BUSY);
      dma_gnt_d = owner_d && (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         owner_q     <= 1'b0;
         run_q       <= '0;
         wait_q      <= '0;
         cmd_q       <= '0;
         mem_req_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         dma_done_q  <= 1'b0;
         dma_gnt_q   <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         run_q       <= run_d;
         wait_q      <= wait_d;
         cmd_q       <= cmd_d;
         mem_req_q   <= mem_req_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         dma_done_q  <= dma_done_d;
         dma_gnt_q   <= dma_gnt_d;
         bus_err_q   <= bus_err_d;
      end
   end

   // Stall must follow cpu_req in the same cycle, hence combinational.
   assign cpu_stall = cpu_req && !(state_q == S_RESP && !owner_q);

   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign dma_done  = dma_done_q;
   assign dma_gnt   = dma_gnt_q;
   assign bus_err   = bus_err_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = cmd_q.addr;
   assign mem_we    = cmd_q.we;
   assign mem_wdata = cmd_q.wdata;
   assign mem_pc    = cmd_q.pc;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed accesses, expected completions
// queued at issue time and checked by an independent monitor.
module tb_dm_arbiter;

   logic        clk, reset;
   logic        cpu_req;
   logic [31:0] cpu_addr, cpu_wdata, cpu_pc, cpu_rdata;
   logic [3:0]  cpu_we;
   logic        cpu_stall;
   logic        dma_req, dma_gnt, dma_done;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic [3:0]  dma_we;
   logic        mem_req, mem_ready, bus_err;
   logic [31:0] mem_addr, mem_wdata, mem_pc, mem_rdata;
   logic [3:0]  mem_we;

   dm_arbiter #(.MAX_CPU_RUN(4), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
      .cpu_pc(cpu_pc), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_pc(mem_pc), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .bus_err(bus_err)
   );

   typedef struct packed {
      logic        who;   // 0 = CPU, 1 = DMA
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   bit   grant_log[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   err_cnt = 0;
   int   slave_lat = 1;
   int   busy_cnt = 0;
   logic [31:0] slave_data = 32'h0;
   logic prev_req = 1'b0;
   logic prev_done = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Slave model: ready in the slave_lat-th BUSY cycle; 0 means never.
   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         busy_cnt  = 0;
         mem_ready = 1'b0;
      end else if (mem_req) begin
         busy_cnt++;
         mem_ready = (slave_lat != 0) && (busy_cnt == slave_lat);
      end else begin
         busy_cnt  = 0;
         mem_ready = 1'b0;
      end
   end
   assign mem_rdata = slave_data;

   task automatic pop_check(input logic who, input logic [31:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL unexpected_completion: got who=%0d data=%h, none expected", who, data);
      end else begin
         e = exp_q.pop_front();
         chk("completion_owner", 32'(who), 32'(e.who));
         chk("completion_rdata", data, e.data);
         chk("completion_bus_err", 32'(bus_err), 32'(e.err));
      end
   endtask

   // Monitor: completions, grant order, idle leakage and pulse widths.
   always @(negedge clk) begin
      if (reset) begin
         if (bus_err) err_cnt++;
         if (cpu_req && !cpu_stall) pop_check(1'b0, cpu_rdata);
         if (dma_done) begin
            chk("dma_done_width", 32'(prev_done), 32'h0);
            pop_check(1'b1, dma_rdata);
         end
         if (mem_req && !prev_req) begin
            grant_log.push_back(dma_gnt);
            chk("grant_mem_pc", mem_pc, dma_gnt ? 32'h0 : cpu_pc);
         end
         if (!mem_req)
            chk("idle_leak", mem_addr | mem_wdata | mem_pc | 32'(mem_we), 32'h0);
      end
      prev_req  = reset && mem_req;
      prev_done = reset && dma_done;
   end

   task automatic cpu_op(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                         input logic [31:0] pc, input int lat, input logic [31:0] d,
                         input logic err, output int stall_cyc, output int we_cyc,
                         output int busy_cyc, output logic [31:0] addr_seen,
                         output logic [3:0] we_seen);
      exp_t e;
      bit   done;
      e.who = 1'b0; e.data = err ? 32'h0 : d; e.err = err;
      exp_q.push_back(e);
      @(posedge clk); #1;
      slave_lat = lat; slave_data = d;
      cpu_req = 1'b1; cpu_addr = a; cpu_we = we; cpu_wdata = wd; cpu_pc = pc;
      stall_cyc = 0; we_cyc = 0; busy_cyc = 0; addr_seen = '0; we_seen = '0; done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (mem_we != 4'h0) we_cyc++;
         if (mem_req) begin busy_cyc++; addr_seen = mem_addr; we_seen = mem_we; end
         if (cpu_stall) stall_cyc++;
         else done = 1'b1;
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL cpu_complete: got no release, required release within 100 cycles");
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_addr = '0; cpu_we = '0; cpu_wdata = '0; cpu_pc = '0;
   endtask

   task automatic dma_op(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                         input int lat, input logic [31:0] d, output int busy_cyc,
                         output logic [31:0] addr_seen);
      exp_t e;
      bit   done;
      e.who = 1'b1; e.data = d; e.err = 1'b0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      slave_lat = lat; slave_data = d;
      dma_req = 1'b1; dma_addr = a; dma_we = we; dma_wdata = wd;
      busy_cyc = 0; addr_seen = '0; done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (mem_req) begin busy_cyc++; addr_seen = mem_addr; end
         if (dma_done) done = 1'b1;
      end
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL dma_complete: got no dma_done, required within 100 cycles");
      end
      @(posedge clk); #1;
      dma_req = 1'b0; dma_addr = '0; dma_we = '0; dma_wdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int          st, wc, bc, eb;
      logic [31:0] as;
      logic [3:0]  ws;
      bit          exp_gnt[10];

      reset = 1'b1;
      cpu_req = 1'b1; cpu_addr = '0; cpu_we = '0; cpu_wdata = '0; cpu_pc = '0;
      dma_req = 1'b0; dma_addr = '0; dma_we = '0; dma_wdata = '0;
      #1 reset = 1'b0;
      #2;
      chk("rst_mem_req",   32'(mem_req), 32'h0);
      chk("rst_mem_bus",   mem_addr | mem_wdata | mem_pc | 32'(mem_we), 32'h0);
      chk("rst_rdata",     cpu_rdata | dma_rdata, 32'h0);
      chk("rst_dma_flags", {29'h0, dma_gnt, dma_done, bus_err}, 32'h0);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'h1);
      #10 cpu_req = 1'b0;
      #9  reset = 1'b1;

      // CPU read, latency 1
      cpu_op(32'h0000_1004, 4'h0, 32'h0, 32'h0000_0400, 1, 32'hDEAD_BEEF, 1'b0, st, wc, bc, as, ws);
      chk("rd_stall_cycles", 32'(st), 32'd2);
      chk("rd_busy_cycles",  32'(bc), 32'd1);
      chk("rd_mem_addr",     as, 32'h0000_1004);
      chk("rd_mem_we",       32'(ws), 32'h0);

      // CPU byte store, latency 3
      cpu_op(32'h0000_2000, 4'b0100, 32'h00AB_0000, 32'h0000_0404, 3, 32'h5A5A_5A5A, 1'b0, st, wc, bc, as, ws);
      chk("sb_stall_cycles", 32'(st), 32'd4);
      chk("sb_we_cycles",    32'(wc), 32'd3);
      chk("sb_mem_we",       32'(ws), 32'h4);

      // Unaligned CPU read, latency 2
      cpu_op(32'h0000_2007, 4'h0, 32'h0, 32'h0000_0408, 2, 32'h1234_5678, 1'b0, st, wc, bc, as, ws);
      chk("ua_mem_addr",     as, 32'h0000_2004);
      chk("ua_stall_cycles", 32'(st), 32'd3);

      // Lone DMA read, then rdata must hold
      dma_op(32'h0000_3003, 4'h0, 32'h0, 2, 32'hCAFE_F00D, bc, as);
      chk("dma_mem_addr",    as, 32'h0000_3000);
      chk("dma_busy_cycles", 32'(bc), 32'd2);
      repeat (3) @(negedge clk);
      chk("dma_rdata_hold",  dma_rdata, 32'hCAFE_F00D);
      chk("dma_gnt_idle",    32'(dma_gnt), 32'h0);

      // Both masters continuously requesting
      grant_log.delete();
      exp_gnt = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      for (int i = 0; i < 10; i++) exp_q.push_back('{exp_gnt[i], 32'h0BAD_F00D, 1'b0});
      @(posedge clk); #1;
      slave_lat = 1; slave_data = 32'h0BAD_F00D;
      cpu_req = 1'b1; cpu_addr = 32'h0000_7000; cpu_pc = 32'h0000_0500;
      dma_req = 1'b1; dma_addr = 32'h0000_8000;
      repeat (30) @(posedge clk);
      #1 cpu_req = 1'b0; dma_req = 1'b0; cpu_addr = '0; cpu_pc = '0; dma_addr = '0;
      @(negedge clk);
      chk("arb_grant_count", 32'(grant_log.size()), 32'd10);
      for (int i = 0; i < 10 && i < grant_log.size(); i++)
         chk($sformatf("arb_grant_%0d", i), 32'(grant_log[i]), 32'(exp_gnt[i]));

      // Slave never ready: timeout
      eb = err_cnt;
      cpu_op(32'h0000_4000, 4'h0, 32'h0, 32'h0000_0600, 0, 32'hFFFF_FFFF, 1'b1, st, wc, bc, as, ws);
      chk("to_busy_cycles",  32'(bc), 32'd16);
      chk("to_stall_cycles", 32'(st), 32'd17);
      chk("to_err_pulses",   32'(err_cnt - eb), 32'd1);

      // Asynchronous reset in the middle of a DMA access
      @(posedge clk); #1;
      slave_lat = 0;
      dma_req = 1'b1; dma_addr = 32'h0000_5000; dma_we = 4'hF; dma_wdata = 32'h7777_7777;
      @(posedge clk); #1;
      @(posedge clk); #2;
      chk("ar_mem_req_before", 32'(mem_req), 32'h1);
      chk("ar_dma_gnt_before", 32'(dma_gnt), 32'h1);
      reset = 1'b0;
      #1;
      chk("ar_mem_req", 32'(mem_req), 32'h0);
      chk("ar_dma_gnt", 32'(dma_gnt), 32'h0);
      chk("ar_mem_we",  32'(mem_we), 32'h0);
      dma_req = 1'b0; dma_addr = '0; dma_we = '0; dma_wdata = '0;
      #3 reset = 1'b1;
      cpu_op(32'h0000_6000, 4'h0, 32'h0, 32'h0000_0700, 1, 32'h600D_CAFE, 1'b0, st, wc, bc, as, ws);
      chk("ar_cpu_stall_cycles", 32'(st), 32'd2);
      chk("ar_cpu_mem_addr",     as, 32'h0000_6000);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
